tinyalu_param: RTL and testbench

//  Parametrised successor of the TinyALU datapath: unsigned ALU with start/done handshake,

---
 rtl/tinyalu_param_if.sv | 23 ++
 rtl/tinyalu_param.sv | 98 +++++++++
 tb/tb_tinyalu_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_param_if.sv
// rtl/tinyalu_param_if.sv - start/done handshake bundle between driver and tinyalu_param
interface tinyalu_param_if #(
   parameter int W = 8
);
   logic             start;
   logic [2:0]       op;
   logic [W-1:0]     A;
   logic [W-1:0]     B;
   logic             busy;
   logic             done;
   logic             err;
   logic [2*W-1:0]   result;

   modport master (
      output start, op, A, B,
      input  busy, done, err, result
   );

   modport slave (
      input  start, op, A, B,
      output busy, done, err, result
   );
endinterface

// File: rtl/tinyalu_param.sv
// rtl/tinyalu_param.sv - width-generic unsigned ALU with multi-cycle MULT and error flag
module tinyalu_param #(
   parameter int W        = 8,
   parameter int MULT_LAT = 3
) (
   input  logic            clk,
   input  logic            reset,
   tinyalu_param_if.slave  bus
);
   localparam int CW = $clog2(MULT_LAT + 1);

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_MULT = 3'b100;

   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

   state_t           state, state_n;
   logic             accept, finish;
   logic [CW-1:0]    cnt, lat_c;
   logic [W-1:0]     a_q, b_q;
   logic [2:0]       op_q;
   logic [2*W-1:0]   ax, bx, res_c, result_q;
   logic             err_c, err_q, done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      accept  = 1'b0;
      finish  = 1'b0;
      case (state)
         IDLE: if (bus.start && bus.op != OP_NOP) begin
            accept  = 1'b1;
            state_n = EXEC;
         end
         EXEC: if (cnt == CW'(1)) begin
            finish  = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign lat_c = (bus.op == OP_MULT) ? CW'(MULT_LAT) : CW'(1);

   // Operands zero-extended to 2W so every op yields the full-width result directly
   assign ax = {{W{1'b0}}, a_q};
   assign bx = {{W{1'b0}}, b_q};

   always_comb begin
      res_c = '0;
      err_c = 1'b0;
      case (op_q)
         OP_ADD:  res_c = ax + bx;
         OP_AND:  res_c = ax & bx;
         OP_XOR:  res_c = ax ^ bx;
         OP_MULT: res_c = ax * bx;
         default: err_c = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         cnt      <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= finish;
         if (accept) begin
            a_q  <= bus.A;
            b_q  <= bus.B;
            op_q <= bus.op;
            cnt  <= lat_c;
         end else if (state == EXEC) begin
            cnt  <= cnt - CW'(1);
         end
         if (finish) begin
            result_q <= res_c;
            err_q    <= err_c;
         end
      end
   end

   assign bus.busy   = (state == EXEC);
   assign bus.done   = done_q;
   assign bus.err    = err_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_tinyalu_param.sv
// tb/tb_tinyalu_param.sv - directed self-checking bench for tinyalu_param (W=8, MULT_LAT=3)
module tb_tinyalu_param;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   tinyalu_param_if #(.W(8)) bus ();

   tinyalu_param #(.W(8), .MULT_LAT(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = 3'b000; bus.A = '0; bus.B = '0;
      reset = 1'b1;
      repeat (2) step();
      total_cnt++;
      if ({bus.busy, bus.done, bus.err} !== 3'b000)
         $display("FAIL reset_flags got=%b exp=000", {bus.busy, bus.done, bus.err});
      else pass_cnt++;
      total_cnt++;
      if (bus.result !== 16'h0000)
         $display("FAIL reset_result got=%h exp=0000", bus.result);
      else pass_cnt++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_add();
      bus.start = 1'b1; bus.op = 3'b001; bus.A = 8'hFF; bus.B = 8'h01;
      step();
      bus.start = 1'b0;
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b10)
         $display("FAIL add_busy got=%b exp=10", {bus.busy, bus.done});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.busy, bus.done, bus.err, bus.result} !== {3'b010, 16'h0100})
         $display("FAIL add_done got=%b/%h exp=010/0100", {bus.busy, bus.done, bus.err}, bus.result);
      else pass_cnt++;
      step();
      total_cnt++;
      if (bus.done !== 1'b0 || bus.result !== 16'h0100)
         $display("FAIL add_hold got=%b/%h exp=0/0100", bus.done, bus.result);
      else pass_cnt++;
   endtask

   task automatic test_mult();
      int extra = 0;
      bus.start = 1'b1; bus.op = 3'b100; bus.A = 8'hFF; bus.B = 8'hFF;
      step();
      bus.op = 3'b001; bus.A = 8'h00; bus.B = 8'h00;
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b10)
         $display("FAIL mult_n1 got=%b exp=10", {bus.busy, bus.done});
      else pass_cnt++;
      step();
      bus.op = 3'b011; bus.A = 8'h01;
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b10)
         $display("FAIL mult_n2 got=%b exp=10", {bus.busy, bus.done});
      else pass_cnt++;
      step();
      bus.start = 1'b0;
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b10)
         $display("FAIL mult_n3 got=%b exp=10", {bus.busy, bus.done});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.busy, bus.done, bus.err, bus.result} !== {3'b010, 16'hFE01})
         $display("FAIL mult_done got=%b/%h exp=010/fe01", {bus.busy, bus.done, bus.err}, bus.result);
      else pass_cnt++;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.done) extra++;
      end
      total_cnt++;
      if (extra !== 0)
         $display("FAIL mult_extra_done got=%0d exp=0", extra);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bus.start = 1'b1; bus.op = 3'b011; bus.A = 8'hA5; bus.B = 8'h0F;
      step();
      step();
      total_cnt++;
      if ({bus.busy, bus.done, bus.result} !== {2'b01, 16'h00AA})
         $display("FAIL b2b_first got=%b/%h exp=01/00aa", {bus.busy, bus.done}, bus.result);
      else pass_cnt++;
      step();
      bus.start = 1'b0;
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b10)
         $display("FAIL b2b_accept got=%b exp=10", {bus.busy, bus.done});
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.busy, bus.done, bus.result} !== {2'b01, 16'h00AA})
         $display("FAIL b2b_second got=%b/%h exp=01/00aa", {bus.busy, bus.done}, bus.result);
      else pass_cnt++;
      step();
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b00)
         $display("FAIL b2b_idle got=%b exp=00", {bus.busy, bus.done});
      else pass_cnt++;
   endtask

   task automatic test_unsupported();
      bus.start = 1'b1; bus.op = 3'b111; bus.A = 8'h12; bus.B = 8'h34;
      step();
      bus.start = 1'b0;
      step();
      total_cnt++;
      if ({bus.done, bus.err, bus.result} !== {2'b11, 16'h0000})
         $display("FAIL unsup_done got=%b/%h exp=11/0000", {bus.done, bus.err}, bus.result);
      else pass_cnt++;
      bus.start = 1'b1; bus.op = 3'b010; bus.A = 8'hF0; bus.B = 8'h3C;
      step();
      bus.start = 1'b0;
      step();
      total_cnt++;
      if ({bus.done, bus.err, bus.result} !== {2'b10, 16'h0030})
         $display("FAIL and_after_err got=%b/%h exp=10/0030", {bus.done, bus.err}, bus.result);
      else pass_cnt++;
   endtask

   task automatic test_nop();
      bus.start = 1'b1; bus.op = 3'b000; bus.A = 8'hFF; bus.B = 8'hFF;
      step();
      total_cnt++;
      if ({bus.busy, bus.done} !== 2'b00)
         $display("FAIL nop_busy got=%b exp=00", {bus.busy, bus.done});
      else pass_cnt++;
      step();
      bus.start = 1'b0;
      total_cnt++;
      if ({bus.busy, bus.done, bus.result} !== {2'b00, 16'h0030})
         $display("FAIL nop_hold got=%b/%h exp=00/0030", {bus.busy, bus.done}, bus.result);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int seen = 0;
      bus.start = 1'b1; bus.op = 3'b100; bus.A = 8'hFF; bus.B = 8'hFF;
      step();
      bus.start = 1'b0;
      step();
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({bus.busy, bus.done, bus.err, bus.result} !== {3'b000, 16'h0000})
         $display("FAIL reset_mid got=%b/%h exp=000/0000", {bus.busy, bus.done, bus.err}, bus.result);
      else pass_cnt++;
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bus.done || bus.busy) seen++;
      end
      total_cnt++;
      if (seen !== 0)
         $display("FAIL reset_mid_no_done got=%0d exp=0", seen);
      else pass_cnt++;
      bus.start = 1'b1; bus.op = 3'b001; bus.A = 8'h03; bus.B = 8'h04;
      step();
      bus.start = 1'b0;
      step();
      total_cnt++;
      if ({bus.done, bus.err, bus.result} !== {2'b10, 16'h0007})
         $display("FAIL add_after_reset got=%b/%h exp=10/0007", {bus.done, bus.err}, bus.result);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_add();
      test_mult();
      test_back_to_back();
      test_unsupported();
      test_nop();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
